sp_fp_to_int_converter: RTL
===========================

Name: sp_fp_to_int_converter

Overview:
- Converts an IEEE754 single-precision float, as produced by the SP adder, into a signed 32-bit two's-complement integer.
- Rounds toward zero (truncation).
- Sequential and iterative: a 1-bit-per-cycle shifter aligns the significand, then a sign stage applies two's complement.
- Sits downstream of the FP datapath as the float-to-integer decode end. Uses a valid/ready handshake on both sides and raises overflow, underflow, invalid and inexact flags.

Parameters:
- WIDTH, 32, float input width and integer output width.
- EXP, 8, exponent field width.
- MANTISSA, 23, stored fraction width (a hidden 1 is prepended for normal numbers).
- BIAS, 127, exponent bias.
- Only the defaults are required to be supported and verified.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- fp_in  input  WIDTH  float operand, sampled on the accept edge.
- in_valid  input  1  operand valid.
- in_ready  output  1  converter idle and able to accept.
- int_out  output  WIDTH  signed integer result; stable while out_valid=1.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  downstream accepts the result.
- overflow_flag  output  1  magnitude does not fit, or input is ±inf; result saturated.
- underflow_flag  output  1  nonzero input with |x|<1; result 0.
- invalid_flag  output  1  input is NaN.
- inexact_flag  output  1  nonzero bits were discarded by truncation.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state goes to IDLE; in_ready=1, out_valid=0.
  - int_out=0 and all flags 0.
  - Any in-flight conversion is discarded, including one in SHIFT, SIGN or DONE.
- States:
  - IDLE: in_ready=1. Accept edge = in_valid & in_ready; fp_in is captured and classified.
  - SHIFT: magnitude register shifted 1 bit per cycle, left or right, while the count decrements.
  - SIGN: conditionally negates, one cycle.
  - DONE: out_valid=1. Leaves DONE on out_valid & out_ready and returns to IDLE. in_ready goes high on the cycle after the handshake; there is no same-cycle bypass.
- in_ready=0 in SHIFT, SIGN and DONE; in_valid is ignored there.
- Classification at accept, with s=sign, E=exponent field, F=fraction, e=E-BIAS:
  - E=255, F≠0 (NaN): int_out=0x80000000, invalid=1. Go directly to DONE.
  - E=255, F=0 (±inf): saturate to 0x7FFFFFFF (s=0) or 0x80000000 (s=1), overflow=1. Go directly to DONE.
  - e≥31: if s=1, E=158 and F=0, result 0x80000000 with no flag. Otherwise saturate as for inf, overflow=1. Go directly to DONE.
  - E=0, F=0 (±0): result 0, no flags. Go directly to DONE.
  - e<0 (includes denormals): result 0, underflow=1, inexact=1. Go directly to DONE.
  - 0≤e≤30 (normal path):
    - magnitude register is loaded with {hidden 1, F}, zero-extended to 32 bits; n=|e-23|.
    - Direction is left if e>23, right if e<23.
    - Next state is SHIFT if n>0, SIGN if n=0.
- SHIFT:
  - Each edge shifts by 1 and decrements the count; the state moves to SIGN when the count reaches 0.
  - On a right shift, a sticky bit ORs in the bit shifted out.
  - Left shift is at most 7 and right shift at most 23; no bit is lost on a left shift.
- SIGN: int_out = s ? (~mag+1) : mag. inexact_flag = sticky.
- Latency, with the accept edge as edge 0:
  - Special cases: out_valid is high after edge 0 (1-cycle latency).
  - Normal path: out_valid is high after edge n+1.
- DONE holding: int_out and all flags are held constant until the handshake completes; out_ready=0 may persist indefinitely.
- Flag scope: flags are mutually consistent per result and are cleared on the next accept.

Test Plan:
- fp_in=0x40490FDB (3.14159) -> int_out=0x00000003, inexact=1, other flags 0; out_valid after edge 23.
- fp_in=0xC2F60000 (-123.0) -> int_out=0xFFFFFF85, all flags 0; out_valid after edge 18. fp_in=0x4B000001 -> 0x00800001, out_valid after edge 1 (n=0).
- fp_in=0x4F000000 (2^31) -> 0x7FFFFFFF, overflow=1. fp_in=0xCF000000 -> 0x80000000, no flags. Both have 1-cycle latency.
- fp_in=0x3F000000 (0.5) -> 0, underflow=1, inexact=1. fp_in=0x80000000 (-0) -> 0, no flags. fp_in=0x00000001 (denormal) -> 0, underflow=1.
- fp_in=0x7FC00000 (NaN) -> 0x80000000, invalid=1. fp_in=0xFF800000 (-inf) -> 0x80000000, overflow=1, invalid=0.
- Handshake and reset:
  - Hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> int_out and flags stable, in_ready=0, no new accept.
  - Release out_ready -> in_ready=1 on the next cycle.
  - Assert rst during SHIFT -> after that edge in_ready=1, out_valid=0, int_out=0.

Source files
------------

// File: rtl/sp_fp_to_int_converter.sv
// Single-precision float to signed 32-bit integer converter, rounding toward zero.
// Iterative: one alignment shift per cycle, then a sign stage, with valid/ready on both sides.
module sp_fp_to_int_converter #(
   parameter int WIDTH    = 32,
   parameter int EXP      = 8,
   parameter int MANTISSA = 23,
   parameter int BIAS     = 127
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] fp_in,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] int_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             overflow_flag,
   output logic             underflow_flag,
   output logic             invalid_flag,
   output logic             inexact_flag
);

   localparam int CNT_W = $clog2(WIDTH);

   localparam logic [EXP-1:0] EXP_MAX_C  = EXP'((1 << EXP) - 1);
   localparam logic [EXP-1:0] BIAS_C     = EXP'(BIAS);
   localparam logic [EXP-1:0] SAT_EXP_C  = EXP'(BIAS + WIDTH - 1);
   localparam logic [EXP-1:0] NORM_EXP_C = EXP'(BIAS + MANTISSA);

   localparam logic [WIDTH-1:0] INT_MIN_C = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] INT_MAX_C = {1'b0, {(WIDTH-1){1'b1}}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      SIGN  = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
   // valid never waits on ready, and the result is held unchanged until it is taken.

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   mag_q, mag_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               left_q, left_d;
   logic               sign_q, sign_d;
   logic               sticky_q, sticky_d;
   logic [WIDTH-1:0]   int_out_q, int_out_d;
   logic               ovf_q, ovf_d;
   logic               unf_q, unf_d;
   logic               inv_q, inv_d;
   logic               inx_q, inx_d;

   logic               in_s;
   logic [EXP-1:0]     in_exp;
   logic [MANTISSA-1:0] in_frac;
   logic               frac_nz;
   logic [EXP-1:0]     diff_left;
   logic [EXP-1:0]     diff_right;
   logic [WIDTH-1:0]   sat_val;
   logic               accept;

   assign in_s     = fp_in[WIDTH-1];
   assign in_exp   = fp_in[WIDTH-2 -: EXP];
   assign in_frac  = fp_in[MANTISSA-1:0];
   assign frac_nz  = |in_frac;
   assign diff_left  = in_exp - NORM_EXP_C;
   assign diff_right = NORM_EXP_C - in_exp;
   assign sat_val  = in_s ? INT_MIN_C : INT_MAX_C;

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign accept    = in_valid & in_ready;

   always_comb begin
      state_d   = state_q;
      mag_d     = mag_q;
      cnt_d     = cnt_q;
      left_d    = left_q;
      sign_d    = sign_q;
      sticky_d  = sticky_q;
      int_out_d = int_out_q;
      ovf_d     = ovf_q;
      unf_d     = unf_q;
      inv_d     = inv_q;
      inx_d     = inx_q;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               // A fresh accept owns all flags; only the matching class sets one back.
               ovf_d    = 1'b0;
               unf_d    = 1'b0;
               inv_d    = 1'b0;
               inx_d    = 1'b0;
               sticky_d = 1'b0;
               sign_d   = in_s;
               state_d  = DONE;
               if (in_exp == EXP_MAX_C && frac_nz) begin
                  int_out_d = INT_MIN_C;
                  inv_d     = 1'b1;
               end else if (in_exp == EXP_MAX_C) begin
                  int_out_d = sat_val;
                  ovf_d     = 1'b1;
               end else if (in_exp >= SAT_EXP_C) begin
                  // -2^31 is the one value at this exponent that fits exactly.
                  if (in_s && in_exp == SAT_EXP_C && !frac_nz) begin
                     int_out_d = INT_MIN_C;
                  end else begin
                     int_out_d = sat_val;
                     ovf_d     = 1'b1;
                  end
               end else if (in_exp == '0 && !frac_nz) begin
                  int_out_d = '0;
               end else if (in_exp < BIAS_C) begin
                  int_out_d = '0;
                  unf_d     = 1'b1;
                  inx_d     = 1'b1;
               end else begin
                  mag_d  = {{(WIDTH-MANTISSA-1){1'b0}}, 1'b1, in_frac};
                  left_d = (in_exp > NORM_EXP_C);
                  if (in_exp > NORM_EXP_C) begin
                     cnt_d = diff_left[CNT_W-1:0];
                  end else begin
                     cnt_d = diff_right[CNT_W-1:0];
                  end
                  state_d = (in_exp == NORM_EXP_C) ? SIGN : SHIFT;
               end
            end
         end

         SHIFT: begin
            if (left_q) begin
               mag_d = {mag_q[WIDTH-2:0], 1'b0};
            end else begin
               mag_d    = {1'b0, mag_q[WIDTH-1:1]};
               sticky_d = sticky_q | mag_q[0];
            end
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = SIGN;
            end
         end

         SIGN: begin
            int_out_d = sign_q ? (~mag_q + WIDTH'(1)) : mag_q;
            inx_d     = sticky_q;
            state_d   = DONE;
         end

         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         mag_q     <= '0;
         cnt_q     <= '0;
         left_q    <= 1'b0;
         sign_q    <= 1'b0;
         sticky_q  <= 1'b0;
         int_out_q <= '0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
         inv_q     <= 1'b0;
         inx_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         mag_q     <= mag_d;
         cnt_q     <= cnt_d;
         left_q    <= left_d;
         sign_q    <= sign_d;
         sticky_q  <= sticky_d;
         int_out_q <= int_out_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
         inv_q     <= inv_d;
         inx_q     <= inx_d;
      end
   end

   assign int_out        = int_out_q;
   assign overflow_flag  = ovf_q;
   assign underflow_flag = unf_q;
   assign invalid_flag   = inv_q;
   assign inexact_flag   = inx_q;

endmodule
